mem_stage: RTL and testbench

Memory-access pipeline stage between execute and writeback. Consumes the registered `ex_to_mem_s` bundle and performs loads and stores on the data memory through a req/ack handshake, stalling upstream while a transfer is outstanding. Non-memory instructions pass through in one cycle. Produces the registered `mem_to_wb_s` bundle, raising exceptions for misaligned or illegal accesses and bus timeouts.

---
 rtl/mem_stage_pkg.sv | 91 +++++++++
 rtl/mem_load_align.sv | 33 +++
 rtl/mem_stage.sv | 188 ++++++++++++++++++
 tb/tb_mem_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared pipeline structures for the memory-access stage.
//
// Contents:
//   ex_to_mem_s  - execute -> memory bundle (address/result, store data,
//                  access kind, destination register, funct3 size code)
//   mem_to_wb_s  - memory -> writeback bundle (valid, reg_write, rd, data)
//   F3_*         - funct3 size/sign codes used by loads and stores
//   EXC_*        - mem_exc encodings
//   mem_state_e  - IDLE/WAIT state encoding of the stage FSM
//   helpers      - access legality check, lane enables, store lane data
package mem_stage_pkg;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [4:0]  rd;
        logic [2:0]  funct3;
    } ex_to_mem_s;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [4:0]  rd;
        logic [31:0] wb_data;
    } mem_to_wb_s;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_ALIGN   = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // True when funct3 names a real access of this direction and the
    // address is naturally aligned for its size.
    function automatic logic access_ok(input logic       is_store,
                                       input logic [2:0] f3,
                                       input logic [1:0] addr);
        logic legal;
        logic aligned;
        case (f3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !is_store;
            default:          legal = 1'b0;
        endcase
        case (f3[1:0])
            2'b01:   aligned = !addr[0];
            2'b10:   aligned = (addr == 2'b00);
            default: aligned = 1'b1;
        endcase
        return legal & aligned;
    endfunction

    // Loads use the same lanes as a store of the same size, so only the
    // size bits of funct3 matter here.
    function automatic logic [3:0] lane_enables(input logic [2:0] f3,
                                                input logic [1:0] addr);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << addr;
            2'b01:   be = addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store datum into every lane it could occupy so the
    // byte enables alone select the target bytes.
    function automatic logic [31:0] lane_data(input logic [2:0]  f3,
                                              input logic [31:0] wdata);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment and extension (purely combinational).
//
// Ports:
//   rdata  in  32  word returned by the data memory
//   addr   in  2   low address bits of the load
//   funct3 in  3   load size/sign code
//   result out 32  selected lane, sign- or zero-extended
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    // Bring the addressed byte/half down to bit 0 before extending.
    assign shifted = rdata >> {addr, 3'b000};

    always_comb begin
        result = rdata;
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   result = {24'h000000, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   result = {16'h0000, shifted[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between execute and writeback.
//
// Non-memory instructions pass straight to writeback after one cycle.
// Loads/stores are checked for legality/alignment, then issued on a
// registered req/ack data-memory port; upstream is stalled until the ack
// (or a timeout) arrives.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ex_valid, ex_to_mem   incoming instruction bundle
//   mem_stall             upstream must hold its bundle
//   dmem_req/we/addr/be/wdata   registered request to data memory
//   dmem_ack, dmem_rdata  completion and load word (same cycle)
//   mem_to_wb             registered writeback bundle
//   mem_exc               one-cycle exception code aligned with mem_to_wb
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  ex_to_mem_s  ex_to_mem,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output mem_to_wb_s  mem_to_wb,
    output logic [1:0]  mem_exc
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // The counter holds the number of ack-less WAIT cycles already seen;
    // the cycle in which it equals this value is the last one allowed.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    mem_state_e  state_reg, state_next;
    logic        req_reg, req_next;
    logic        we_reg, we_next;
    logic [31:0] addr_reg, addr_next;
    logic [3:0]  be_reg, be_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [2:0]  funct3_reg, funct3_next;
    logic [4:0]  rd_reg, rd_next;
    logic        reg_write_reg, reg_write_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    mem_to_wb_s  wb_reg, wb_next;
    logic [1:0]  exc_reg, exc_next;

    logic        is_mem_op;
    logic        good_access;
    logic        timeout_hit;
    logic [31:0] load_data;

    mem_load_align u_load_align (
        .rdata  (dmem_rdata),
        .addr   (addr_reg[1:0]),
        .funct3 (funct3_reg),
        .result (load_data)
    );

    assign is_mem_op   = ex_to_mem.mem_read | ex_to_mem.mem_write;
    assign good_access = access_ok(ex_to_mem.mem_write, ex_to_mem.funct3,
                                   ex_to_mem.alu_result[1:0]);
    // An ack in the final allowed cycle still completes the transfer.
    assign timeout_hit = (state_reg == ST_WAIT) && !dmem_ack && (cnt_reg == CNT_LAST);

    always_comb begin
        state_next     = state_reg;
        req_next       = req_reg;
        we_next        = we_reg;
        addr_next      = addr_reg;
        be_next        = be_reg;
        wdata_next     = wdata_reg;
        funct3_next    = funct3_reg;
        rd_next        = rd_reg;
        reg_write_next = reg_write_reg;
        cnt_next       = cnt_reg;
        wb_next        = '0;
        exc_next       = EXC_NONE;
        mem_stall      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (!is_mem_op) begin
                        wb_next.valid     = 1'b1;
                        wb_next.reg_write = ex_to_mem.reg_write;
                        wb_next.rd        = ex_to_mem.rd;
                        wb_next.wb_data   = ex_to_mem.alu_result;
                    end else if (!good_access) begin
                        // Faulting access retires immediately with the
                        // offending address as data and no register write.
                        wb_next.valid     = 1'b1;
                        wb_next.reg_write = 1'b0;
                        wb_next.rd        = ex_to_mem.rd;
                        wb_next.wb_data   = ex_to_mem.alu_result;
                        exc_next          = EXC_ALIGN;
                    end else begin
                        state_next     = ST_WAIT;
                        req_next       = 1'b1;
                        we_next        = ex_to_mem.mem_write;
                        addr_next      = ex_to_mem.alu_result;
                        be_next        = lane_enables(ex_to_mem.funct3,
                                                      ex_to_mem.alu_result[1:0]);
                        wdata_next     = lane_data(ex_to_mem.funct3,
                                                   ex_to_mem.write_data);
                        funct3_next    = ex_to_mem.funct3;
                        rd_next        = ex_to_mem.rd;
                        reg_write_next = ex_to_mem.reg_write;
                        cnt_next       = '0;
                        mem_stall      = 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                if (dmem_ack) begin
                    state_next        = ST_IDLE;
                    req_next          = 1'b0;
                    wb_next.valid     = 1'b1;
                    wb_next.reg_write = reg_write_reg & !we_reg;
                    wb_next.rd        = rd_reg;
                    wb_next.wb_data   = we_reg ? 32'h0 : load_data;
                end else if (timeout_hit) begin
                    state_next        = ST_IDLE;
                    req_next          = 1'b0;
                    wb_next.valid     = 1'b1;
                    wb_next.reg_write = 1'b0;
                    wb_next.rd        = rd_reg;
                    exc_next          = EXC_TIMEOUT;
                end else begin
                    cnt_next  = cnt_reg + CW'(1);
                    mem_stall = 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            req_reg       <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            be_reg        <= '0;
            wdata_reg     <= '0;
            funct3_reg    <= '0;
            rd_reg        <= '0;
            reg_write_reg <= 1'b0;
            cnt_reg       <= '0;
            wb_reg        <= '0;
            exc_reg       <= EXC_NONE;
        end else begin
            state_reg     <= state_next;
            req_reg       <= req_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            be_reg        <= be_next;
            wdata_reg     <= wdata_next;
            funct3_reg    <= funct3_next;
            rd_reg        <= rd_next;
            reg_write_reg <= reg_write_next;
            cnt_reg       <= cnt_next;
            wb_reg        <= wb_next;
            exc_reg       <= exc_next;
        end
    end

    assign dmem_req   = req_reg;
    assign dmem_we    = we_reg;
    assign dmem_addr  = addr_reg;
    assign dmem_be    = be_reg;
    assign dmem_wdata = wdata_reg;
    assign mem_to_wb  = wb_reg;
    assign mem_exc    = exc_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage (TIMEOUT_CYCLES = 4).
// Inputs change 1 time unit after a rising edge; outputs are sampled on
// the falling edge of the same cycle.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    ex_to_mem_s  ex_to_mem;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    mem_to_wb_s  mem_to_wb;
    logic [1:0]  mem_exc;

    integer errors = 0;
    integer checks = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_to_mem  (ex_to_mem),
        .mem_stall  (mem_stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .mem_to_wb  (mem_to_wb),
        .mem_exc    (mem_exc)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive_op(input logic rd_en, input logic wr_en, input logic regw,
                            input logic [4:0] rd, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata);
        ex_valid             = 1'b1;
        ex_to_mem.alu_result = addr;
        ex_to_mem.write_data = wdata;
        ex_to_mem.mem_read   = rd_en;
        ex_to_mem.mem_write  = wr_en;
        ex_to_mem.reg_write  = regw;
        ex_to_mem.rd         = rd;
        ex_to_mem.funct3     = f3;
    endtask

    task automatic clear_ex();
        ex_valid  = 1'b0;
        ex_to_mem = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_ex();
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        cyc();
        mid();
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
        checks++; if ({dmem_we, dmem_be, dmem_addr, dmem_wdata} !== 69'd0) begin errors++; $display("FAIL reset_req_regs: got we=%b be=%b addr=%h wdata=%h expected all 0", dmem_we, dmem_be, dmem_addr, dmem_wdata); end
        checks++; if (mem_to_wb !== '0) begin errors++; $display("FAIL reset_wb: got %h expected 0", mem_to_wb); end
        checks++; if (mem_exc !== 2'b00) begin errors++; $display("FAIL reset_exc: got %b expected 00", mem_exc); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", mem_stall); end
        rst_n = 1'b1;
        $display("tx: reset released");
    endtask

    task automatic test_alu_passthrough();
        for (int i = 0; i < 3; i++) begin
            cyc();
            drive_op(1'b0, 1'b0, 1'b1, 5'd5, 3'b000, 32'h0000_1234, 32'h0);
            mid();
            checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL alu_stall[%0d]: got %b expected 0", i, mem_stall); end
            if (i > 0) begin
                checks++; if ({mem_to_wb.valid, mem_to_wb.reg_write, mem_to_wb.rd, mem_to_wb.wb_data} !== {1'b1, 1'b1, 5'd5, 32'h0000_1234}) begin errors++; $display("FAIL alu_beat[%0d]: got v=%b rw=%b rd=%0d data=%h expected v=1 rw=1 rd=5 data=00001234", i - 1, mem_to_wb.valid, mem_to_wb.reg_write, mem_to_wb.rd, mem_to_wb.wb_data); end
            end
        end
        cyc();
        clear_ex();
        mid();
        checks++; if ({mem_to_wb.valid, mem_to_wb.wb_data} !== {1'b1, 32'h0000_1234}) begin errors++; $display("FAIL alu_beat[2]: got v=%b data=%h expected v=1 data=00001234", mem_to_wb.valid, mem_to_wb.wb_data); end
        cyc();
        mid();
        checks++; if (mem_to_wb.valid !== 1'b0) begin errors++; $display("FAIL alu_idle: got valid=%b expected 0", mem_to_wb.valid); end
        $display("tx: 3 x ALU pass-through rd=5 data=00001234");
    endtask

    task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp_data);
        cyc();
        drive_op(1'b1, 1'b0, 1'b1, 5'd7, f3, 32'h0000_0103, 32'h0);
        mid();
        checks++; if ({mem_stall, dmem_req} !== 2'b10) begin errors++; $display("FAIL lb_c0 f3=%b: got stall=%b req=%b expected stall=1 req=0", f3, mem_stall, dmem_req); end
        cyc();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h80FF_FF7F;
        mid();
        checks++; if ({dmem_req, dmem_we, dmem_be, dmem_addr, mem_stall} !== {1'b1, 1'b0, 4'b1000, 32'h0000_0103, 1'b0}) begin errors++; $display("FAIL lb_c1 f3=%b: got req=%b we=%b be=%b addr=%h stall=%b expected req=1 we=0 be=1000 addr=00000103 stall=0", f3, dmem_req, dmem_we, dmem_be, dmem_addr, mem_stall); end
        cyc();
        dmem_ack = 1'b0;
        clear_ex();
        mid();
        checks++; if ({mem_to_wb.valid, mem_to_wb.reg_write, mem_to_wb.rd, mem_to_wb.wb_data, mem_exc, dmem_req} !== {1'b1, 1'b1, 5'd7, exp_data, 2'b00, 1'b0}) begin errors++; $display("FAIL lb_c2 f3=%b: got v=%b rw=%b rd=%0d data=%h exc=%b req=%b expected v=1 rw=1 rd=7 data=%h exc=00 req=0", f3, mem_to_wb.valid, mem_to_wb.reg_write, mem_to_wb.rd, mem_to_wb.wb_data, mem_exc, dmem_req, exp_data); end
        $display("tx: load f3=%b addr=00000103 rdata=80ffff7f -> %h", f3, mem_to_wb.wb_data);
    endtask

    task automatic test_sh_delayed_ack();
        cyc();
        drive_op(1'b0, 1'b1, 1'b0, 5'd9, F3_H, 32'h0000_0202, 32'hAAAA_BEEF);
        mid();
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL sh_c0_stall: got %b expected 1", mem_stall); end
        for (int k = 1; k <= 3; k++) begin
            cyc();
            mid();
            checks++; if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, mem_stall} !== {1'b1, 1'b1, 4'b1100, 32'h0000_0202, 32'hBEEF_BEEF, 1'b1}) begin errors++; $display("FAIL sh_c%0d: got req=%b we=%b be=%b addr=%h wdata=%h stall=%b expected req=1 we=1 be=1100 addr=00000202 wdata=beefbeef stall=1", k, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, mem_stall); end
        end
        cyc();
        dmem_ack = 1'b1;
        mid();
        checks++; if ({dmem_req, dmem_addr, dmem_wdata, mem_stall} !== {1'b1, 32'h0000_0202, 32'hBEEF_BEEF, 1'b0}) begin errors++; $display("FAIL sh_c4: got req=%b addr=%h wdata=%h stall=%b expected req=1 addr=00000202 wdata=beefbeef stall=0", dmem_req, dmem_addr, dmem_wdata, mem_stall); end
        cyc();
        dmem_ack = 1'b0;
        clear_ex();
        mid();
        checks++; if ({mem_to_wb.valid, mem_to_wb.reg_write, mem_exc, dmem_req} !== {1'b1, 1'b0, 2'b00, 1'b0}) begin errors++; $display("FAIL sh_c5: got v=%b rw=%b exc=%b req=%b expected v=1 rw=0 exc=00 req=0", mem_to_wb.valid, mem_to_wb.reg_write, mem_exc, dmem_req); end
        $display("tx: SH addr=00000202 data=aaaabeef ack in C4");
    endtask

    task automatic test_bad_access(input logic is_store, input logic [2:0] f3, input logic [31:0] addr);
        cyc();
        drive_op(!is_store, is_store, !is_store, 5'd11, f3, addr, 32'h1234_5678);
        mid();
        checks++; if ({mem_stall, dmem_req} !== 2'b00) begin errors++; $display("FAIL bad_c0 f3=%b addr=%h: got stall=%b req=%b expected 0 0", f3, addr, mem_stall, dmem_req); end
        cyc();
        clear_ex();
        mid();
        checks++; if ({mem_to_wb.valid, mem_to_wb.reg_write, mem_exc, dmem_req} !== {1'b1, 1'b0, 2'b01, 1'b0}) begin errors++; $display("FAIL bad_c1 f3=%b addr=%h: got v=%b rw=%b exc=%b req=%b expected v=1 rw=0 exc=01 req=0", f3, addr, mem_to_wb.valid, mem_to_wb.reg_write, mem_exc, dmem_req); end
        cyc();
        mid();
        checks++; if ({mem_to_wb.valid, mem_exc} !== {1'b0, 2'b00}) begin errors++; $display("FAIL bad_c2 f3=%b: got v=%b exc=%b expected v=0 exc=00", f3, mem_to_wb.valid, mem_exc); end
        $display("tx: bad access store=%b f3=%b addr=%h -> exc 01", is_store, f3, addr);
    endtask

    task automatic test_timeout();
        cyc();
        drive_op(1'b1, 1'b0, 1'b1, 5'd12, F3_W, 32'h0000_0100, 32'h0);
        mid();
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL to_c0_stall: got %b expected 1", mem_stall); end
        for (int k = 1; k <= 4; k++) begin
            cyc();
            mid();
            checks++; if ({dmem_req, mem_stall} !== {1'b1, (k < 4)}) begin errors++; $display("FAIL to_c%0d: got req=%b stall=%b expected req=1 stall=%b", k, dmem_req, mem_stall, (k < 4)); end
        end
        cyc();
        drive_op(1'b0, 1'b0, 1'b1, 5'd3, 3'b000, 32'h0000_0055, 32'h0);
        mid();
        checks++; if ({dmem_req, mem_exc, mem_to_wb.valid, mem_to_wb.reg_write, mem_stall} !== {1'b0, 2'b10, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL to_c5: got req=%b exc=%b v=%b rw=%b stall=%b expected req=0 exc=10 v=1 rw=0 stall=0", dmem_req, mem_exc, mem_to_wb.valid, mem_to_wb.reg_write, mem_stall); end
        cyc();
        clear_ex();
        mid();
        checks++; if ({mem_to_wb.valid, mem_to_wb.rd, mem_to_wb.wb_data, mem_exc} !== {1'b1, 5'd3, 32'h0000_0055, 2'b00}) begin errors++; $display("FAIL to_next_alu: got v=%b rd=%0d data=%h exc=%b expected v=1 rd=3 data=00000055 exc=00", mem_to_wb.valid, mem_to_wb.rd, mem_to_wb.wb_data, mem_exc); end
        $display("tx: LW addr=00000100 timeout -> exc 10, then ALU rd=3");
    endtask

    task automatic test_back_to_back();
        cyc();
        drive_op(1'b1, 1'b0, 1'b1, 5'd1, F3_W, 32'h0000_0104, 32'h0);
        mid();
        cyc();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1234_5678;
        mid();
        checks++; if ({dmem_req, mem_stall} !== 2'b10) begin errors++; $display("FAIL b2b_ack1: got req=%b stall=%b expected req=1 stall=0", dmem_req, mem_stall); end
        cyc();
        dmem_ack = 1'b0;
        drive_op(1'b1, 1'b0, 1'b1, 5'd2, F3_HU, 32'h0000_0106, 32'h0);
        mid();
        checks++; if ({mem_to_wb.valid, mem_to_wb.rd, mem_to_wb.wb_data, mem_stall, dmem_req} !== {1'b1, 5'd1, 32'h1234_5678, 1'b1, 1'b0}) begin errors++; $display("FAIL b2b_first_wb: got v=%b rd=%0d data=%h stall=%b req=%b expected v=1 rd=1 data=12345678 stall=1 req=0", mem_to_wb.valid, mem_to_wb.rd, mem_to_wb.wb_data, mem_stall, dmem_req); end
        cyc();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE_0000;
        mid();
        checks++; if ({dmem_req, dmem_be, dmem_addr} !== {1'b1, 4'b1100, 32'h0000_0106}) begin errors++; $display("FAIL b2b_req2: got req=%b be=%b addr=%h expected req=1 be=1100 addr=00000106", dmem_req, dmem_be, dmem_addr); end
        cyc();
        dmem_ack = 1'b0;
        clear_ex();
        mid();
        checks++; if ({mem_to_wb.valid, mem_to_wb.rd, mem_to_wb.wb_data} !== {1'b1, 5'd2, 32'h0000_CAFE}) begin errors++; $display("FAIL b2b_second_wb: got v=%b rd=%0d data=%h expected v=1 rd=2 data=0000cafe", mem_to_wb.valid, mem_to_wb.rd, mem_to_wb.wb_data); end
        $display("tx: back-to-back LW 00000104 then LHU 00000106");
    endtask

    task automatic test_reset_mid_wait();
        cyc();
        drive_op(1'b0, 1'b1, 1'b0, 5'd0, F3_W, 32'h0000_0300, 32'h1122_3344);
        mid();
        cyc();
        mid();
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rmw_req_before: got %b expected 1", dmem_req); end
        cyc();
        rst_n = 1'b0;
        clear_ex();
        #1;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rmw_req_async: got %b expected 0", dmem_req); end
        mid();
        cyc();
        mid();
        checks++; if ({mem_to_wb.valid, mem_exc} !== {1'b0, 2'b00}) begin errors++; $display("FAIL rmw_in_reset: got v=%b exc=%b expected v=0 exc=00", mem_to_wb.valid, mem_exc); end
        rst_n = 1'b1;
        cyc();
        mid();
        checks++; if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, mem_to_wb, mem_exc, mem_stall} !== '0) begin errors++; $display("FAIL rmw_after: got req=%b we=%b be=%b addr=%h wdata=%h wb=%h exc=%b stall=%b expected all 0", dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, mem_to_wb, mem_exc, mem_stall); end
        $display("tx: reset asserted during WAIT of SW 00000300");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_passthrough();
        test_load_byte(F3_B,  32'hFFFF_FF80);
        test_load_byte(F3_BU, 32'h0000_0080);
        test_sh_delayed_ack();
        test_bad_access(1'b0, F3_W, 32'h0000_0101);
        test_bad_access(1'b1, 3'b011, 32'h0000_0100);
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
